// File: rtl/counter_bank.sv
// Bank of independent up/down counters with per-channel wrap/saturate/modulo/one-shot
// modes and a zero-latency cascade chain from each channel to the one above it.

module counter_bank_ch #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] INCREMENT = WIDTH'(1),
  parameter logic [WIDTH-1:0] INITIAL   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             down,
  input  logic [1:0]       mode,
  input  logic             casc_ok,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_count,
  output logic [WIDTH-1:0] count,
  output logic             overflow,
  output logic             done,
  output logic             ev
);
  typedef enum logic [1:0] {M_WRAP = 2'b00, M_SAT = 2'b01, M_MOD = 2'b10, M_ONESHOT = 2'b11} mode_e;

  localparam logic [WIDTH:0] STEP = {1'b0, INCREMENT};

  mode_e          md;
  logic [WIDTH:0] cnt_x, lim_x, sum, dif;
  logic [WIDTH-1:0] nxt;
  logic           borrow, adv, hit;

  assign md     = mode_e'(mode);
  assign cnt_x  = {1'b0, count};
  assign lim_x  = {1'b0, limit};
  assign sum    = cnt_x + STEP;
  assign dif    = cnt_x - STEP;
  assign borrow = dif[WIDTH];

  always_comb begin
    nxt = count;
    hit = 1'b0;
    case (md)
      M_WRAP: begin
        nxt = down ? dif[WIDTH-1:0] : sum[WIDTH-1:0];
        hit = down ? borrow : sum[WIDTH];
      end
      M_MOD: begin
        if (!down) begin
          if (cnt_x >= lim_x) begin nxt = '0; hit = 1'b1; end
          else nxt = sum[WIDTH-1:0];
        end else begin
          if (borrow) begin nxt = limit; hit = 1'b1; end
          else nxt = dif[WIDTH-1:0];
        end
      end
      default: begin
        // saturate and one-shot: event only on the step that lands on the boundary
        if (!down) begin
          nxt = (sum > lim_x) ? limit : sum[WIDTH-1:0];
          hit = (nxt == limit) && (count != limit);
        end else begin
          nxt = borrow ? '0 : dif[WIDTH-1:0];
          hit = (nxt == '0) && (count != '0);
        end
      end
    endcase
  end

  assign adv = enable & ~done & casc_ok;
  assign ev  = adv & ~load & hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= INITIAL;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else if (load) begin
      count    <= load_count;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (adv) count <= nxt;
      if (ev) begin
        overflow <= 1'b1;
        if (md == M_ONESHOT) done <= 1'b1;
      end
    end
  end
endmodule

module counter_bank #(
  parameter int               WIDTH     = 8,
  parameter int               CHANNELS  = 4,
  parameter logic [WIDTH-1:0] INCREMENT = WIDTH'(1),
  parameter logic [WIDTH-1:0] INITIAL   = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       up0_down1,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [CHANNELS-1:0]       cascade,
  input  logic [WIDTH*CHANNELS-1:0] limit,
  input  logic [CHANNELS-1:0]       load,
  input  logic [WIDTH*CHANNELS-1:0] load_count,
  output logic [WIDTH*CHANNELS-1:0] count,
  output logic [CHANNELS-1:0]       tc,
  output logic [CHANNELS-1:0]       overflow,
  output logic [CHANNELS-1:0]       done
);
  logic [CHANNELS-1:0] ev, ev_below;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    // channel 0 sees a permanently-true event below it, so its cascade bit is a no-op
    if (i == 0) begin : g_base
      assign ev_below[i] = 1'b1;
    end else begin : g_link
      assign ev_below[i] = ev[i-1];
    end

    counter_bank_ch #(
      .WIDTH(WIDTH), .INCREMENT(INCREMENT), .INITIAL(INITIAL)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable[i]),
      .down       (up0_down1[i]),
      .mode       (mode[2*i +: 2]),
      .casc_ok    (~cascade[i] | ev_below[i]),
      .limit      (limit[WIDTH*i +: WIDTH]),
      .load       (load[i]),
      .load_count (load_count[WIDTH*i +: WIDTH]),
      .count      (count[WIDTH*i +: WIDTH]),
      .overflow   (overflow[i]),
      .done       (done[i]),
      .ev         (ev[i])
    );
  end

  // terminal count is the event vector delayed one clock; load already masks ev
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tc <= '0;
    else        tc <= ev;
  end
endmodule
